// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the IF-stage PC logic
// Purpose: FSM state encoding, instruction size, default reset PC and a word-align helper.
// Ports: none (package).
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  // Clear the byte-offset bits so a value is a legal instruction address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_update_unit_if.sv
// rtl/pc_update_unit_if.sv - fetch-control bundle between pipeline control and the PC unit
// Purpose: groups hazard/backpressure, branch/jump redirect inputs and the fetch outputs.
// Ports (as seen by the slave = PC unit):
//   in : stall, imem_ready, branch_taken, branch_pc_plus4, branch_offset_sl2,
//        jump, jump_pc_hi, jump_index
//   out: pc, pc_plus4, fetch_valid, flush_if, redirect_pending
interface pc_update_unit_if;

  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_pc_plus4;
  logic [31:0] branch_offset_sl2;
  logic        jump;
  logic [3:0]  jump_pc_hi;
  logic [25:0] jump_index;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush_if;
  logic        redirect_pending;

  modport master (
    output stall, imem_ready, branch_taken, branch_pc_plus4, branch_offset_sl2,
           jump, jump_pc_hi, jump_index,
    input  pc, pc_plus4, fetch_valid, flush_if, redirect_pending
  );

  modport slave (
    input  stall, imem_ready, branch_taken, branch_pc_plus4, branch_offset_sl2,
           jump, jump_pc_hi, jump_index,
    output pc, pc_plus4, fetch_valid, flush_if, redirect_pending
  );

endinterface

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - combinational redirect detection and target selection
// Purpose: forms branch and jump targets; a taken branch beats a jump because it is older.
// Ports:
//   in : branch_taken, branch_pc_plus4[31:0], branch_offset_sl2[31:0],
//        jump, jump_pc_hi[3:0], jump_index[25:0]
//   out: redirect, target[31:0]
module branch_target_calc
  import mips_pkg::*;
(
  input  logic        branch_taken,
  input  logic [31:0] branch_pc_plus4,
  input  logic [31:0] branch_offset_sl2,
  input  logic        jump,
  input  logic [3:0]  jump_pc_hi,
  input  logic [25:0] jump_index,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  // Offset low bits are not trusted from the shifter; the sum wraps modulo 2^32.
  assign br_tgt = branch_pc_plus4 + word_align(branch_offset_sl2);
  assign j_tgt  = {jump_pc_hi, jump_index, 2'b00};

  assign redirect = branch_taken || jump;
  assign target   = branch_taken ? br_tgt : j_tgt;

endmodule

// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - IF-stage PC register with next-PC selection and redirect holding
// Purpose: sequential fetch, branch/jump redirect, stall/imem backpressure, latched redirect
//          while blocked, and a registered one-cycle flush_if after each applied redirect.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   pcif  : pc_update_unit_if.slave (control inputs, pc/pc_plus4/fetch_valid/flush_if/
//           redirect_pending outputs)
module pc_update_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             reset,
  pc_update_unit_if.slave  pcif
);

  localparam logic [1:0] S_BOOT = BOOT;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_PEND = PEND;

  logic [1:0]  state, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] pend_target, pend_n;
  logic        flush_q, flush_n;

  logic        advance;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_pc;

  branch_target_calc u_tgt (
    .branch_taken      (pcif.branch_taken),
    .branch_pc_plus4   (pcif.branch_pc_plus4),
    .branch_offset_sl2 (pcif.branch_offset_sl2),
    .jump              (pcif.jump),
    .jump_pc_hi        (pcif.jump_pc_hi),
    .jump_index        (pcif.jump_index),
    .redirect          (redirect),
    .target            (target)
  );

  assign advance = !pcif.stall && pcif.imem_ready;
  assign seq_pc  = pc_q + 32'(INSTR_BYTES);

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    pend_n  = pend_target;
    flush_n = 1'b0;
    case (state)
      S_BOOT: begin
        // One dead cycle after reset; inputs are not looked at.
        state_n = S_RUN;
      end
      S_RUN: begin
        if (redirect && advance) begin
          pc_n    = target;
          flush_n = 1'b1;
        end else if (redirect) begin
          // Blocked: remember where to go, keep presenting the current fetch.
          pend_n  = target;
          state_n = S_PEND;
        end else if (advance) begin
          pc_n = seq_pc;
        end
      end
      S_PEND: begin
        // Anything redirecting now comes from the wrong path; only the latched target counts.
        if (advance) begin
          pc_n    = pend_target;
          flush_n = 1'b1;
          state_n = S_RUN;
        end
      end
      default: begin
        state_n = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_BOOT;
      pc_q        <= word_align(RESET_PC);
      pend_target <= 32'h0;
      flush_q     <= 1'b0;
    end else begin
      state       <= state_n;
      pc_q        <= pc_n;
      pend_target <= pend_n;
      flush_q     <= flush_n;
    end
  end

  assign pcif.pc               = pc_q;
  assign pcif.pc_plus4         = seq_pc;
  assign pcif.fetch_valid      = (state != S_BOOT);
  assign pcif.flush_if         = flush_q;
  assign pcif.redirect_pending = (state == S_PEND);

endmodule
